// File: rtl/register_file.sv
// register_file: multi-entry register bank with one write port and two
// independent registered read ports, a synchronous clear-all, per-entry
// valid flags and optional write-to-read bypass.
//
// Parameters:
//   WIDTH     data width of every entry and of d/qa/qb
//   DEPTH     number of entries (>= 2, need not be a power of two)
//   BYPASS    1: reads see the array after this edge's clear/write
//             0: reads see the array before this edge
//   RESET_VAL value loaded into entries and read outputs on reset/clear
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   load     write enable
//   waddr    write address
//   d        write data
//   clear    synchronous clear of all entries and valid flags (beats load)
//   raddr_a  read address, port A
//   raddr_b  read address, port B
//   qa, qb   registered read data
//   va, vb   registered valid flag of the entry read
//   err      sticky flag for any out-of-range address; cleared by reset only
module register_file #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter bit BYPASS = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] d,
  input  logic             clear,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] qa,
  output logic [WIDTH-1:0] qb,
  output logic             va,
  output logic             vb,
  output logic             err
);

  logic [WIDTH-1:0] mem_r     [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic [WIDTH-1:0] mem_nxt_s [DEPTH];
  logic [DEPTH-1:0] valid_nxt_s;
  logic [WIDTH-1:0] rd_mem_s  [DEPTH];
  logic [DEPTH-1:0] rd_valid_s;
  logic             err_hit_s;

  // An address is legal when it names an existing entry; with a
  // non-power-of-two DEPTH the top address codes are unused.
  function automatic logic in_range(input logic [AW-1:0] addr);
    in_range = (32'(addr) < DEPTH);
  endfunction

  // Post-edge array contents: clear wins over load; an out-of-range waddr
  // matches no entry, so it writes nothing.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (clear) begin
        mem_nxt_s[i]   = RESET_VAL;
        valid_nxt_s[i] = 1'b0;
      end else if (load && (waddr == AW'(i))) begin
        mem_nxt_s[i]   = d;
        valid_nxt_s[i] = 1'b1;
      end else begin
        mem_nxt_s[i]   = mem_r[i];
        valid_nxt_s[i] = valid_r[i];
      end
    end
  end

  // Read source: forwarded post-edge contents or the current array.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (BYPASS) begin
        rd_mem_s[i]   = mem_nxt_s[i];
        rd_valid_s[i] = valid_nxt_s[i];
      end else begin
        rd_mem_s[i]   = mem_r[i];
        rd_valid_s[i] = valid_r[i];
      end
    end
  end

  // Any illegal address sampled this edge; waddr only counts when the
  // write is not suppressed by clear.
  always_comb begin
    err_hit_s = (!clear && load && !in_range(waddr))
              || !in_range(raddr_a) || !in_range(raddr_b);
  end

  // Storage array and valid flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= RESET_VAL;
      end
      valid_r <= {DEPTH{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= mem_nxt_s[i];
      end
      valid_r <= valid_nxt_s;
    end
  end

  // Registered read ports and the sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      qa  <= RESET_VAL;
      qb  <= RESET_VAL;
      va  <= 1'b0;
      vb  <= 1'b0;
      err <= 1'b0;
    end else begin
      if (in_range(raddr_a)) begin
        qa <= rd_mem_s[raddr_a];
        va <= rd_valid_s[raddr_a];
      end else begin
        qa <= RESET_VAL;
        va <= 1'b0;
      end
      if (in_range(raddr_b)) begin
        qb <= rd_mem_s[raddr_b];
        vb <= rd_valid_s[raddr_b];
      end else begin
        qb <= RESET_VAL;
        vb <= 1'b0;
      end
      err <= err | err_hit_s;
    end
  end

endmodule

// File: doc/register_file.md
# register_file

Parametrised multi-entry register bank. It generalises the team's single 8-bit load/reset register into DEPTH entries of WIDTH bits, with one write port, two independent registered read ports, a synchronous clear-all, per-entry valid flags and optional write-to-read bypass. It is the storage element for the datapath blocks that previously instantiated several discrete registers side by side.

## Interface
- WIDTH, 8, data width of every entry and of d/qa/qb.
- DEPTH, 8, number of entries; any value ≥2, not necessarily a power of two. AW = clog2(DEPTH) (local, derived).
- BYPASS, 1, 1 = reads return the post-edge array contents (write/clear forwarded); 0 = reads return the pre-edge contents.
- RESET_VAL, 0, WIDTH-bit value loaded into entries and outputs on reset and clear.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- load  in  1  write enable.
- waddr  in  AW  write address.
- d  in  WIDTH  write data.
- clear  in  1  synchronous clear of all entries and valid flags.
- raddr_a  in  AW  read address, port A.
- raddr_b  in  AW  read address, port B.
- qa  out  WIDTH  registered read data, port A.
- qb  out  WIDTH  registered read data, port B.
- va  out  1  valid flag of the entry read on port A.
- vb  out  1  valid flag of the entry read on port B.
- err  out  1  sticky flag for any out-of-range address use.

## Operation
- Reset (reset=0, immediate, independent of clk): every entry = RESET_VAL; all valid flags = 0; qa = qb = RESET_VAL; va = vb = 0; err = 0. State holds while reset=0.
- Priority at each rising edge: clear > load.
- Clear (clear=1): every entry <= RESET_VAL and every valid flag <= 0. load is ignored that cycle: no write and no err from waddr.
- Write (clear=0, load=1, waddr<DEPTH): entry[waddr] <= d and valid[waddr] <= 1.
- Write out of range (clear=0, load=1, waddr≥DEPTH): no entry changes; err <= 1.
- Hold (clear=0, load=0): array is unchanged; d and waddr are don't-care.
- Read, each port independently, every cycle with no enable:
  - raddr<DEPTH: q <= entry[raddr] and v <= valid[raddr].
  - BYPASS=1: the value read is the array after this edge's clear/write. A write to the same address returns d with v=1. A clear returns RESET_VAL with v=0.
  - BYPASS=0: the value read is the array before this edge.
  - raddr≥DEPTH: q <= RESET_VAL, v <= 0, err <= 1.
- Both ports may read the same address, including the one being written. Both then return identical data.
- err is cleared only by reset. clear does not clear err.

## Timing
- Write latency: 1 edge. Data written at edge N is readable at qa/qb after edge N+1 (BYPASS=0), or already after edge N (BYPASS=1).
- Read latency: 1 edge from raddr to q/v. q/v are driven directly from flops, with no combinational path from inputs.
- err asserts after the edge that sampled the offending address.
- Reset deassertion is synchronous-safe: the first state-changing edge is the first rising clk edge with reset=1.
- If reset is asserted mid-operation, it overrides everything immediately. Any in-flight write or read is lost.

## Test plan
WIDTH=8, DEPTH=6 (AW=3) unless noted.
- Reset: drive reset=0 mid-cycle with load=1, d=8'hFF -> qa=qb=8'h00, va=vb=0, err=0 immediately. After release, all six entries read 8'h00 with v=0.
- Write/read: write 8'hA9 to entry 2 and 8'h07 to entry 5. Next cycle read raddr_a=2, raddr_b=5 -> qa=8'hA9, va=1, qb=8'h07, vb=1. A cycle with load=0, d=8'h55 leaves both unchanged.
- Bypass: BYPASS=1, load=1, waddr=3, d=8'h3C, raddr_a=3 -> after the same edge qa=8'h3C, va=1. With BYPASS=0 the same stimulus gives the old value (8'h00, va=0), then 8'h3C one edge later.
- Clear vs load: clear=1 and load=1 (waddr=1, d=8'h11) on the same edge -> all entries 8'h00, valid=0. Entry 1 is not written and err stays 0.
- Out of range: load=1, waddr=6, d=8'hEE -> no entry changes, err=1. raddr_b=7 -> qb=8'h00, vb=0. err stays 1 through a clear and drops only on reset=0.
- Parameter sweep: WIDTH=16, DEPTH=4, RESET_VAL=16'hBEEF -> after reset all reads return 16'hBEEF with v=0. All 2-bit addresses are legal and err never asserts.
